// File: rtl/bcd_pkg.sv
// Shared state encoding and sizing helper for the BCD stopwatch controller.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVF   = 2'd3
  } sw_state_t;

  // Smallest prescaler width (at least 1) that can hold div-1.
  function automatic int unsigned cnt_width(input int unsigned div);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(div)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_inc12.sv
// Three-digit BCD incrementor: dout = din + 1 in BCD, carry set on 999 -> 000.
module bcd_inc12 (
  input  logic [11:0] din,
  output logic [11:0] dout,
  output logic        carry
);

  // Returns {carry_out, next_digit}; any digit at or above 9 wraps to 0 when carried into.
  function automatic logic [4:0] inc_digit(input logic [3:0] dig, input logic cin);
    logic [4:0] res;
    if (!cin) begin
      res = {1'b0, dig};
    end else if (dig >= 4'd9) begin
      res = {1'b1, 4'd0};
    end else begin
      res = {1'b0, dig + 4'd1};
    end
    return res;
  endfunction

  logic [4:0] u_s;
  logic [4:0] t_s;
  logic [4:0] h_s;

  // Ripple the carry through units, tens and hundreds.
  always_comb begin
    u_s   = inc_digit(din[3:0],  1'b1);
    t_s   = inc_digit(din[7:4],  u_s[4]);
    h_s   = inc_digit(din[11:8], t_s[4]);
    dout  = {h_s[3:0], t_s[3:0], u_s[3:0]};
    carry = h_s[4];
  end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Three-digit BCD stopwatch: IDLE/RUN/PAUSE/OVF control, DIV-cycle prescaler,
// and registered digit/status outputs.
module bcd_stopwatch_ctrl #(
  parameter int unsigned DIV  = 100000,
  parameter int unsigned WRAP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic       running,
  output logic       ovf
);
  import bcd_pkg::*;

  localparam int unsigned   PW      = cnt_width(DIV);
  localparam logic [PW-1:0] PMAX    = PW'(DIV - 32'd1);
  localparam logic          WRAP_EN = (WRAP != 32'd0);

  sw_state_t   state_r;
  sw_state_t   state_nxt_s;
  logic [PW-1:0] presc_r;
  logic [PW-1:0] presc_nxt_s;
  logic [11:0] digits_s;
  logic [11:0] digits_nxt_s;
  logic [11:0] inc_s;
  logic        carry_s;
  logic        step_s;
  logic        running_nxt_s;
  logic        ovf_nxt_s;

  assign digits_s = {d2, d1, d0};

  bcd_inc12 u_inc (
    .din   (digits_s),
    .dout  (inc_s),
    .carry (carry_s)
  );

  // A step is lost if stop or clear lands on the terminal prescaler cycle.
  always_comb begin
    step_s = (state_r == ST_RUN) && (presc_r == PMAX) && !stop && !clear;
  end

  // Next-state, prescaler and digit logic with clear > stop > start priority.
  always_comb begin
    state_nxt_s  = state_r;
    presc_nxt_s  = presc_r;
    digits_nxt_s = digits_s;
    if (clear) begin
      state_nxt_s  = ST_IDLE;
      presc_nxt_s  = {PW{1'b0}};
      digits_nxt_s = 12'h000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !stop) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_nxt_s = ST_PAUSE;
          end else if (step_s) begin
            presc_nxt_s = {PW{1'b0}};
            // Saturating build holds 999 and parks in OVF instead of wrapping.
            if (carry_s && !WRAP_EN) begin
              state_nxt_s = ST_OVF;
            end else begin
              digits_nxt_s = inc_s;
            end
          end else begin
            presc_nxt_s = presc_r + PW'(1'b1);
          end
        end
        ST_PAUSE: begin
          if (start && !stop) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_PAUSE;
          end
        end
        ST_OVF: begin
          state_nxt_s = ST_OVF;
        end
        default: begin
          state_nxt_s  = ST_IDLE;
          presc_nxt_s  = {PW{1'b0}};
          digits_nxt_s = 12'h000;
        end
      endcase
    end
    running_nxt_s = (state_nxt_s == ST_RUN);
    if (WRAP_EN) begin
      ovf_nxt_s = step_s && carry_s;
    end else begin
      ovf_nxt_s = (state_nxt_s == ST_OVF);
    end
  end

  // State, prescaler and output registers; reset overrides every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      presc_r <= {PW{1'b0}};
      d0      <= 4'd0;
      d1      <= 4'd0;
      d2      <= 4'd0;
      running <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      presc_r <= presc_nxt_s;
      d0      <= digits_nxt_s[3:0];
      d1      <= digits_nxt_s[7:4];
      d2      <= digits_nxt_s[11:8];
      running <= running_nxt_s;
      ovf     <= ovf_nxt_s;
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl: DIV=4 table plus DIV=1 saturate/wrap sequences.
module tb_bcd_stopwatch_ctrl;

  logic clk = 1'b0;
  logic reset, start, stop, clear;
  logic [3:0] a_d0, a_d1, a_d2, b_d0, b_d1, b_d2, c_d0, c_d1, c_d2;
  logic a_run, a_ovf, b_run, b_ovf, c_run, c_ovf;
  int checks = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  bcd_stopwatch_ctrl #(.DIV(4), .WRAP(0)) u_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .d0(a_d0), .d1(a_d1), .d2(a_d2), .running(a_run), .ovf(a_ovf));

  bcd_stopwatch_ctrl #(.DIV(1), .WRAP(0)) u_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .d0(b_d0), .d1(b_d1), .d2(b_d2), .running(b_run), .ovf(b_ovf));

  bcd_stopwatch_ctrl #(.DIV(1), .WRAP(1)) u_c (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .d0(c_d0), .d1(c_d1), .d2(c_d2), .running(c_run), .ovf(c_ovf));

  typedef struct {
    logic        rs, st, sp, cl;
    logic [11:0] dig;
    logic        run, ov;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(input logic rs, st, sp, cl, input logic [11:0] dig,
                              input logic run, ov);
    vec_t v;
    v.rs = rs; v.st = st; v.sp = sp; v.cl = cl; v.dig = dig; v.run = run; v.ov = ov;
    return v;
  endfunction

  function automatic logic [11:0] to_bcd(input int n);
    return {4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic tick(input logic rs, st, sp, cl);
    reset = rs; start = st; stop = sp; clear = cl;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (a_d0 > 4'd9 || a_d1 > 4'd9 || a_d2 > 4'd9 ||
          b_d0 > 4'd9 || b_d1 > 4'd9 || b_d2 > 4'd9 ||
          c_d0 > 4'd9 || c_d1 > 4'd9 || c_d2 > 4'd9) begin
        failures++;
        $display("FAIL bcd_valid: a=%h%h%h b=%h%h%h c=%h%h%h required each digit <= 9",
                 a_d2, a_d1, a_d0, b_d2, b_d1, b_d0, c_d2, c_d1, c_d0);
      end
    end
  end

  initial begin
    // DIV=4 vectors: inputs held one cycle, outputs expected after that edge.
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0); // reset
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0); // start -> RUN, p0
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0); // p1
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0); // p2
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0); // p3
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h001, 1'b1, 1'b0); // step
    tbl[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 12'h001, 1'b0, 1'b0); // stop -> PAUSE
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h001, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 12'h001, 1'b1, 1'b0); // resume, p0
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 12'h001, 1'b1, 1'b0); // start ignored, p1
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h001, 1'b1, 1'b0); // p2
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h001, 1'b1, 1'b0); // p3
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h002, 1'b1, 1'b0); // step
    tbl[13] = mk(1'b0, 1'b1, 1'b1, 1'b0, 12'h002, 1'b0, 1'b0); // stop beats start
    tbl[14] = mk(1'b0, 1'b1, 1'b0, 1'b0, 12'h002, 1'b1, 1'b0); // resume p0
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h002, 1'b1, 1'b0); // p1
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h002, 1'b1, 1'b0); // p2
    tbl[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h002, 1'b1, 1'b0); // p3
    tbl[18] = mk(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0); // clear+stop on step
    tbl[19] = mk(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0); // run again
    tbl[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    tbl[21] = mk(1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0); // reset+clear mid-RUN
    tbl[22] = mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0); // stays IDLE

    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    for (int i = 0; i < 23; i++) begin
      tick(tbl[i].rs, tbl[i].st, tbl[i].sp, tbl[i].cl);
      chk($sformatf("vec%0d digits", i), {20'd0, a_d2, a_d1, a_d0}, {20'd0, tbl[i].dig});
      chk($sformatf("vec%0d running", i), {31'd0, a_run}, {31'd0, tbl[i].run});
      chk($sformatf("vec%0d ovf", i), {31'd0, a_ovf}, {31'd0, tbl[i].ov});
    end

    // DIV=4: one-cycle start then 40 cycles gives ten steps.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("div4_run40 digits", {20'd0, a_d2, a_d1, a_d0}, 32'h010);
    chk("div4_run40 running", {31'd0, a_run}, 32'd1);

    // Pause at prescaler 2; resume must step on the second RUN cycle.
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pause running", {31'd0, a_run}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("pause%0d digits", i), {20'd0, a_d2, a_d1, a_d0}, 32'h010);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    chk("resume running", {31'd0, a_run}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("resume 1st cycle digits", {20'd0, a_d2, a_d1, a_d0}, 32'h010);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("resume 2nd cycle digits", {20'd0, a_d2, a_d1, a_d0}, 32'h011);

    // DIV=1: count every RUN cycle through carries up to 999.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 1; n <= 999; n++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (n == 9 || n == 10 || n == 99 || n == 100 || n == 998 || n == 999) begin
        chk($sformatf("sat count %0d", n), {20'd0, b_d2, b_d1, b_d0}, {20'd0, to_bcd(n)});
        chk($sformatf("wrap count %0d", n), {20'd0, c_d2, c_d1, c_d0}, {20'd0, to_bcd(n)});
      end
    end
    chk("sat at999 running", {31'd0, b_run}, 32'd1);
    chk("wrap at999 ovf", {31'd0, c_ovf}, 32'd0);

    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat ovf digits", {20'd0, b_d2, b_d1, b_d0}, 32'h999);
    chk("sat ovf flag", {31'd0, b_ovf}, 32'd1);
    chk("sat ovf running", {31'd0, b_run}, 32'd0);
    chk("wrap rollover digits", {20'd0, c_d2, c_d1, c_d0}, 32'h000);
    chk("wrap rollover ovf", {31'd0, c_ovf}, 32'd1);
    chk("wrap rollover running", {31'd0, c_run}, 32'd1);

    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat hold digits", {20'd0, b_d2, b_d1, b_d0}, 32'h999);
    chk("sat hold ovf", {31'd0, b_ovf}, 32'd1);
    chk("wrap pulse ends", {31'd0, c_ovf}, 32'd0);
    chk("wrap next digits", {20'd0, c_d2, c_d1, c_d0}, 32'h001);

    tick(1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovf start ignored running", {31'd0, b_run}, 32'd0);
    chk("ovf start ignored ovf", {31'd0, b_ovf}, 32'd1);
    chk("ovf start ignored digits", {20'd0, b_d2, b_d1, b_d0}, 32'h999);

    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf clear digits", {20'd0, b_d2, b_d1, b_d0}, 32'h000);
    chk("ovf clear ovf", {31'd0, b_ovf}, 32'd0);
    chk("ovf clear running", {31'd0, b_run}, 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("after clear idle digits", {20'd0, b_d2, b_d1, b_d0}, 32'h000);
    chk("after clear idle running", {31'd0, b_run}, 32'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
BCD_STOPWATCH_CTRL -- requirements
Module: bcd_stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 100000, meaning clock cycles per count step (legal range 1..2^24).
REQ-002 The block SHALL have parameter WRAP, default 0, meaning 0 = saturate at 999 and enter OVF, 1 = roll over to 000.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level, sampled each cycle; run request.
REQ-006 stop  input  1  level, sampled each cycle; pause request.
REQ-007 clear  input  1  level, sampled each cycle; zero digits, return to IDLE.
REQ-008 d0  output  4  BCD units digit, registered.
REQ-009 d1  output  4  BCD tens digit, registered.
REQ-010 d2  output  4  BCD hundreds digit, registered.
REQ-011 running  output  1  high while state = RUN, registered.
REQ-012 ovf  output  1  WRAP=0: high while state = OVF; WRAP=1: one-cycle pulse on 999->000.

Function
REQ-013 States SHALL be IDLE, RUN, PAUSE and OVF, with OVF reachable only when WRAP=0.
REQ-014 Command priority in any cycle SHALL be clear > stop > start.
REQ-015 clear SHALL, from any state, set digits to 000, prescaler to 0 and ovf to 0, and move to IDLE on the next edge.
REQ-016 start in IDLE or PAUSE SHALL move to RUN on the next edge; start in RUN or OVF SHALL be ignored.
REQ-017 stop in RUN SHALL move to PAUSE; stop in any other state SHALL be ignored.
REQ-018 The prescaler SHALL count 0..DIV-1 only in RUN and hold its value in PAUSE, so that resume continues the partial interval.
REQ-019 A step SHALL occur in a RUN cycle where prescaler = DIV-1 and no stop or clear is asserted; the prescaler SHALL return to 0 on that step.
REQ-020 On a step, the digits SHALL load the BCD increment of their current value, visible one edge later.
REQ-021 A step coinciding with stop or clear SHALL be discarded: digits unchanged by stop, zeroed by clear.
REQ-022 With WRAP=0 and digits = 999, a step SHALL leave digits at 999, move to OVF and drive running low.
REQ-023 With WRAP=1 and digits = 999, a step SHALL load 000, pulse ovf for exactly one cycle and stay in RUN.
REQ-024 OVF SHALL be exited only by clear or reset.
REQ-025 With DIV=1, a step SHALL occur on every RUN cycle.
REQ-026 Digits SHALL always hold valid BCD values (0..9 each).

Reset
REQ-027 Reset SHALL override all inputs, including clear.
REQ-028 Reset SHALL force state IDLE, d0=d1=d2=0, prescaler 0, running 0 and ovf 0 on the next edge.
REQ-029 Reset asserted mid-RUN SHALL discard any pending step.

Structure
REQ-030 State encoding and the DIV counter-width function SHALL reside in the shared package bcd_pkg.
REQ-031 The digit increment SHALL be performed by one instance of the existing 3-digit BCD incrementor bcd_inc12, fed by the digit registers.
REQ-032 FSM, prescaler and digit registers SHALL live in this module; no other sub-modules are permitted.

Verification
REQ-033 DIV=4, WRAP=0: reset, start for 1 cycle, run 40 cycles -> digits 010 and running=1.
REQ-034 DIV=4: start, then stop at prescaler=2 and hold 10 cycles, then start -> digits frozen during pause; next step after exactly 2 RUN cycles (prescaler=2 carried over, hits DIV-1=3 on the 2nd RUN cycle and steps).
REQ-035 DIV=1, WRAP=0: preload to 998 by running, run 3 more cycles -> 999, ovf=1, running=0; start ignored; clear -> 000, IDLE.
REQ-036 DIV=1, WRAP=1: at 999, next RUN cycle -> 000, ovf high for exactly 1 cycle, running stays 1.
REQ-037 DIV=4: assert clear and stop in the step cycle -> digits 000, IDLE; then assert reset and clear together mid-RUN -> all outputs 0 next edge.
REQ-038 DIV=1: digit carries 009->010 and 099->100 -> every output digit stays within 0..9, checked by an assertion throughout.
